// File: rtl/phase_arbiter.sv
// Traffic/pedestrian phase arbiter: main, side and walk requesters served
// round-robin with minimum green, yellow, all-red clearance and walk timing.
module phase_arbiter #(
    parameter int T_GREEN = 6,
    parameter int T_YEL   = 2,
    parameter int T_CLR   = 1,
    parameter int T_WALK  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] req,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk_light,
    output logic [2:0] grant,
    output logic [2:0] pending
);

    typedef enum logic [2:0] {INIT, CLR, MAIN_G, MAIN_Y, SIDE_G, SIDE_Y, WALK} state_t;

    localparam logic [1:0] L_OFF = 2'd0, L_GRN = 2'd1, L_YEL = 2'd2, L_RED = 2'd3;

    state_t     state, state_n, arb_state;
    logic [3:0] cnt;
    logic [4:0] ticks_done;
    logic [1:0] rr_ptr, rr_ptr_n, arb_idx;
    logic [2:0] grant_n, pending_n;
    logic [1:0] main_n, side_n;
    logic       walk_n;

    // Ticks elapsed in this phase including the current one; widened so a
    // saturated counter still compares correctly.
    assign ticks_done = {1'b0, cnt} + 5'd1;

    // Round-robin: search upward from the slot after the last grant; the
    // loop runs far-to-near so the nearest pending slot is the last write.
    always_comb begin
        arb_idx = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            if (pending[(int'(rr_ptr) + k) % 3])
                arb_idx = 2'((int'(rr_ptr) + k) % 3);
        end
        case (arb_idx)
            2'd1:    arb_state = SIDE_G;
            2'd2:    arb_state = WALK;
            default: arb_state = MAIN_G;
        endcase
    end

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        if (tick) begin
            case (state)
                INIT:   state_n = CLR;
                CLR:    if (ticks_done >= 5'(T_CLR)) begin
                            state_n  = arb_state;
                            rr_ptr_n = arb_idx;
                        end
                MAIN_G: if (ticks_done >= 5'(T_GREEN) && (pending[1] || pending[2]))
                            state_n = MAIN_Y;
                SIDE_G: if (ticks_done >= 5'(T_GREEN) && (pending[0] || pending[2]))
                            state_n = SIDE_Y;
                MAIN_Y, SIDE_Y:
                        if (ticks_done >= 5'(T_YEL)) state_n = CLR;
                WALK:   if (ticks_done >= 5'(T_WALK)) state_n = CLR;
                default: state_n = INIT;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registers track the state.
    always_comb begin
        main_n  = L_RED;
        side_n  = L_RED;
        walk_n  = 1'b0;
        grant_n = 3'b000;
        case (state_n)
            INIT:   begin main_n = L_OFF; side_n = L_OFF; end
            MAIN_G: begin main_n = L_GRN; grant_n = 3'b001; end
            MAIN_Y: begin main_n = L_YEL; grant_n = 3'b001; end
            SIDE_G: begin side_n = L_GRN; grant_n = 3'b010; end
            SIDE_Y: begin side_n = L_YEL; grant_n = 3'b010; end
            WALK:   begin walk_n = 1'b1;  grant_n = 3'b100; end
            default: ;
        endcase
    end

    // A request from the requester being served is dropped; a new grant clears its bit.
    assign pending_n = (pending | (req & ~grant)) & ~grant_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            cnt        <= 4'd0;
            pending    <= 3'b000;
            rr_ptr     <= 2'd2;
            main_light <= L_OFF;
            side_light <= L_OFF;
            walk_light <= 1'b0;
            grant      <= 3'b000;
        end else begin
            state      <= state_n;
            rr_ptr     <= rr_ptr_n;
            pending    <= pending_n;
            main_light <= main_n;
            side_light <= side_n;
            walk_light <= walk_n;
            grant      <= grant_n;
            if (state_n != state)
                cnt <= 4'd0;
            else if (tick && cnt != 4'hF)
                cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_phase_arbiter.sv
// Bench for phase_arbiter: directed vector table, hand-written corner
// sequences and random stimulus against a phase-level reference model.
module tb_phase_arbiter;

    localparam int T_GREEN = 6, T_YEL = 2, T_CLR = 1, T_WALK = 3;

    logic       clk = 1'b0;
    logic       reset, tick;
    logic [2:0] req;
    logic [1:0] main_light, side_light;
    logic       walk_light;
    logic [2:0] grant, pending;

    phase_arbiter #(.T_GREEN(T_GREEN), .T_YEL(T_YEL), .T_CLR(T_CLR), .T_WALK(T_WALK)) dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req),
        .main_light(main_light), .side_light(side_light), .walk_light(walk_light),
        .grant(grant), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // Reference model: phase name, ticks elapsed in phase, pending set, last served.
    localparam int P_INIT = 0, P_CLR = 1, P_MG = 2, P_MY = 3, P_SG = 4, P_SY = 5, P_WALK = 6;
    int         m_ph = P_INIT, m_el = 0, m_last = 2;
    logic [2:0] m_pend = 3'b000;

    function automatic logic [2:0] grant_of(input int ph);
        if (ph == P_MG || ph == P_MY) return 3'b001;
        if (ph == P_SG || ph == P_SY) return 3'b010;
        if (ph == P_WALK)             return 3'b100;
        return 3'b000;
    endfunction

    // {main, side, walk}
    function automatic logic [4:0] lights_of(input int ph);
        case (ph)
            P_INIT: return {2'd0, 2'd0, 1'b0};
            P_MG:   return {2'd1, 2'd3, 1'b0};
            P_MY:   return {2'd2, 2'd3, 1'b0};
            P_SG:   return {2'd3, 2'd1, 1'b0};
            P_SY:   return {2'd3, 2'd2, 1'b0};
            P_WALK: return {2'd3, 2'd3, 1'b1};
            default: return {2'd3, 2'd3, 1'b0};
        endcase
    endfunction

    task automatic model_step(input logic r, input logic tk, input logic [2:0] rq);
        int np, pick;
        if (r) begin
            m_ph = P_INIT; m_el = 0; m_pend = 3'b000; m_last = 2;
            return;
        end
        np = m_ph;
        if (tk) begin
            case (m_ph)
                P_INIT: np = P_CLR;
                P_CLR: if (m_el + 1 >= T_CLR) begin
                    pick = -1;
                    for (int k = 1; k <= 3; k++)
                        if (pick < 0 && m_pend[(m_last + k) % 3]) pick = (m_last + k) % 3;
                    if (pick < 0) pick = 0;
                    np = (pick == 0) ? P_MG : (pick == 1) ? P_SG : P_WALK;
                    m_last = pick;
                end
                P_MG: if (m_el + 1 >= T_GREEN && (m_pend[1] || m_pend[2])) np = P_MY;
                P_SG: if (m_el + 1 >= T_GREEN && (m_pend[0] || m_pend[2])) np = P_SY;
                P_MY, P_SY: if (m_el + 1 >= T_YEL) np = P_CLR;
                P_WALK: if (m_el + 1 >= T_WALK) np = P_CLR;
                default: ;
            endcase
        end
        m_pend = (m_pend | (rq & ~grant_of(m_ph))) & ~grant_of(np);
        if (np != m_ph) m_el = 0;
        else if (tk) m_el++;
        m_ph = np;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] outs();
        return {main_light, side_light, walk_light, grant, pending};
    endfunction

    // One clock: drive, advance the model on the edge, compare just after it.
    task automatic cyc(input logic r, input logic tk, input logic [2:0] rq);
        reset = r; tick = tk; req = rq;
        @(posedge clk);
        model_step(r, tk, rq);
        #1;
        check("model", 32'(outs()), 32'({lights_of(m_ph), grant_of(m_ph), m_pend}));
        check("safety", 32'((main_light == 2'd1 && side_light == 2'd1) ||
                            ((main_light == 2'd1 || side_light == 2'd1) && walk_light)), 32'd0);
    endtask

    typedef struct {
        logic        rst;
        logic        tk;
        logic [2:0]  rq;
        logic [10:0] exp;   // {main, side, walk, grant, pending}
    } vec_t;

    vec_t vecs[12];

    initial begin
        int side_at, walk_at, walk_cnt, side_entries;
        logic prev_side;

        reset = 1'b1; tick = 1'b0; req = 3'b000;

        // Reset, boot to main rest, side request served after min green.
        vecs[0]  = '{1'b1, 1'b1, 3'b000, {2'd0, 2'd0, 1'b0, 3'b000, 3'b000}};
        vecs[1]  = '{1'b0, 1'b1, 3'b000, {2'd3, 2'd3, 1'b0, 3'b000, 3'b000}};
        vecs[2]  = '{1'b0, 1'b1, 3'b000, {2'd1, 2'd3, 1'b0, 3'b001, 3'b000}};
        vecs[3]  = '{1'b0, 1'b1, 3'b010, {2'd1, 2'd3, 1'b0, 3'b001, 3'b010}};
        for (int i = 4; i <= 7; i++)
            vecs[i] = '{1'b0, 1'b1, 3'b000, {2'd1, 2'd3, 1'b0, 3'b001, 3'b010}};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, {2'd2, 2'd3, 1'b0, 3'b001, 3'b010}};
        vecs[9]  = '{1'b0, 1'b1, 3'b000, {2'd2, 2'd3, 1'b0, 3'b001, 3'b010}};
        vecs[10] = '{1'b0, 1'b1, 3'b000, {2'd3, 2'd3, 1'b0, 3'b000, 3'b010}};
        vecs[11] = '{1'b0, 1'b1, 3'b000, {2'd3, 2'd1, 1'b0, 3'b010, 3'b000}};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].rst, vecs[i].tk, vecs[i].rq);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Rest in main green indefinitely with no requests.
        cyc(1'b1, 1'b1, 3'b000);
        repeat (30) cyc(1'b0, 1'b1, 3'b000);
        check("rest_main", 32'({main_light, side_light, grant}), 32'({2'd1, 2'd3, 3'b001}));

        // Side and walk both pending: side first, then walk for T_WALK ticks, then main.
        cyc(1'b0, 1'b1, 3'b110);
        side_at = -1; walk_at = -1; walk_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, 1'b1, 3'b000);
            if (side_light == 2'd1 && side_at < 0) side_at = i;
            if (walk_light) begin
                walk_cnt++;
                if (walk_at < 0) walk_at = i;
                check("walk_lights", 32'({main_light, side_light}), 32'({2'd3, 2'd3}));
            end
        end
        check("side_before_walk", 32'(side_at >= 0 && walk_at > side_at), 32'd1);
        check("walk_len", 32'(walk_cnt), 32'(T_WALK));
        check("back_to_main", 32'({main_light, grant}), 32'({2'd1, 3'b001}));

        // Side request while side is green is dropped; no second side phase.
        cyc(1'b0, 1'b1, 3'b010);
        for (int i = 0; i < 40 && side_light != 2'd1; i++) cyc(1'b0, 1'b1, 3'b000);
        check("reach_side_g", 32'(side_light), 32'd1);
        repeat (3) cyc(1'b0, 1'b1, 3'b010);
        check("side_req_dropped", 32'(pending[1]), 32'd0);
        cyc(1'b0, 1'b1, 3'b001);
        side_entries = 0; prev_side = 1'b1;
        repeat (40) begin
            cyc(1'b0, 1'b1, 3'b000);
            if (side_light == 2'd1 && !prev_side) side_entries++;
            prev_side = (side_light == 2'd1);
        end
        check("no_second_side", 32'(side_entries), 32'd0);

        // Tick held low in main yellow freezes the phase timer.
        cyc(1'b0, 1'b1, 3'b010);
        for (int i = 0; i < 40 && main_light != 2'd2; i++) cyc(1'b0, 1'b1, 3'b000);
        check("reach_main_y", 32'(main_light), 32'd2);
        repeat (20) cyc(1'b0, 1'b0, 3'b000);
        check("frozen_y", 32'(main_light), 32'd2);
        cyc(1'b0, 1'b1, 3'b000);
        check("y_after_1tick", 32'(main_light), 32'd2);
        cyc(1'b0, 1'b1, 3'b000);
        check("y_to_clr", 32'({main_light, side_light, grant}), 32'({2'd3, 2'd3, 3'b000}));

        // Reset in the middle of walk.
        cyc(1'b0, 1'b1, 3'b100);
        for (int i = 0; i < 60 && !walk_light; i++) cyc(1'b0, 1'b1, 3'b000);
        check("reach_walk", 32'(walk_light), 32'd1);
        cyc(1'b0, 1'b1, 3'b000);
        cyc(1'b1, 1'b1, 3'b111);
        check("reset_mid_walk", 32'(outs()), 32'd0);
        cyc(1'b0, 1'b1, 3'b000);
        check("restart_clr", 32'({main_light, side_light, grant}), 32'({2'd3, 2'd3, 3'b000}));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7,
                {$urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
